// File: rtl/silencer_pkg.sv
// Shared types and sizing for the silencer frame sequencer.
package silencer_pkg;

   localparam int unsigned DEPTH_DEFAULT   = 249;
   localparam int unsigned ADDR_WIDTH      = $clog2(DEPTH_DEFAULT);
   localparam int unsigned RATE_WIDTH      = 16;
   localparam int unsigned INTENSITY_WIDTH = 16;
   localparam int unsigned PHASE_WIDTH     = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_COLLECT = 2'd3
   } state_e;

endpackage

// File: rtl/delay_fifo.sv
// Fixed-length shift pipeline: o_data is i_data delayed by DEPTH clock cycles.
module delay_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   // Shift one stage per cycle; cleared on reset so nothing in flight survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_data;
         for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/silencer_sequencer.sv
// Frame sequencer: streams one RAM frame to the interpolator per trigger,
// tracks interpolator completions and queues one extra trigger.
module silencer_sequencer
   import silencer_pkg::*;
#(
   parameter int unsigned DEPTH       = DEPTH_DEFAULT,
   parameter int unsigned RAM_LATENCY = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_trig,
   input  logic [RATE_WIDTH-1:0]      i_update_rate_intensity_cfg,
   input  logic [RATE_WIDTH-1:0]      i_update_rate_phase_cfg,
   input  logic                       i_overrun_clr,
   output logic                       o_ram_en,
   output logic [$clog2(DEPTH)-1:0]   o_ram_addr,
   input  logic [INTENSITY_WIDTH-1:0] i_ram_intensity,
   input  logic [PHASE_WIDTH-1:0]     i_ram_phase,
   output logic                       o_din_valid,
   output logic [INTENSITY_WIDTH-1:0] o_intensity,
   output logic [PHASE_WIDTH-1:0]     o_phase,
   output logic [RATE_WIDTH-1:0]      o_update_rate_intensity,
   output logic [RATE_WIDTH-1:0]      o_update_rate_phase,
   input  logic                       i_dout_valid,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overrun
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);

   state_e                      r_state;
   logic                        r_ram_en;
   logic [AW-1:0]               r_ram_addr;
   logic [CW-1:0]               r_din_cnt;
   logic [CW-1:0]               r_dout_cnt;
   logic [RATE_WIDTH-1:0]       r_rate_intensity;
   logic [RATE_WIDTH-1:0]       r_rate_phase;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_pending;
   logic                        r_overrun;
   logic [INTENSITY_WIDTH-1:0]  r_intensity;
   logic [PHASE_WIDTH-1:0]      r_phase;

   logic w_din_valid;
   logic w_accept;
   logic w_trig_busy;
   logic w_last_din;
   logic w_last_dout;
   logic w_streaming;

   assign w_accept    = (r_state == ST_IDLE) && (i_trig || r_pending);
   assign w_trig_busy = i_trig && (r_state != ST_IDLE);
   assign w_last_din  = w_din_valid && (r_din_cnt == LAST_CNT);
   assign w_last_dout = i_dout_valid && (r_dout_cnt == LAST_CNT);
   assign w_streaming = (r_state == ST_FETCH) || (r_state == ST_DRAIN);

   // RAM_EN delayed by the RAM latency becomes the data-valid strobe.
   delay_fifo #(
      .WIDTH (1),
      .DEPTH (RAM_LATENCY)
   ) u_valid_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (r_ram_en),
      .o_data (w_din_valid)
   );

   // Frame FSM with address generation, valid/completion counters and rate latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= ST_IDLE;
         r_ram_en         <= 1'b0;
         r_ram_addr       <= '0;
         r_din_cnt        <= '0;
         r_dout_cnt       <= '0;
         r_rate_intensity <= '0;
         r_rate_phase     <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE) begin
            if (w_din_valid)  r_din_cnt  <= r_din_cnt + CW'(1);
            if (i_dout_valid) r_dout_cnt <= r_dout_cnt + CW'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state          <= ST_FETCH;
                  r_busy           <= 1'b1;
                  r_ram_en         <= 1'b1;
                  r_ram_addr       <= '0;
                  r_din_cnt        <= '0;
                  r_dout_cnt       <= '0;
                  r_rate_intensity <= i_update_rate_intensity_cfg;
                  r_rate_phase     <= i_update_rate_phase_cfg;
               end
            end
            ST_FETCH: begin
               if (r_ram_addr == LAST_ADDR) begin
                  r_ram_en <= 1'b0;
                  r_state  <= ST_DRAIN;
               end else begin
                  r_ram_addr <= r_ram_addr + AW'(1);
               end
            end
            ST_DRAIN: begin
               // A zero-latency interpolator can finish on the last valid itself.
               if (w_last_din) begin
                  if (w_last_dout) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               if (w_last_dout) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // One-deep trigger queue and sticky overrun (set beats clear).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pending <= r_pending && i_trig;
         end else if (w_trig_busy && !r_pending) begin
            r_pending <= 1'b1;
         end
         if (w_trig_busy && r_pending) begin
            r_overrun <= 1'b1;
         end else if (i_overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // RAM read data arrives one cycle ahead of the delayed valid; registering it aligns the two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_intensity <= '0;
         r_phase     <= '0;
      end else if (w_streaming) begin
         r_intensity <= i_ram_intensity;
         r_phase     <= i_ram_phase;
      end
   end

   assign o_ram_en                = r_ram_en;
   assign o_ram_addr              = r_ram_addr;
   assign o_din_valid             = w_din_valid;
   assign o_intensity             = r_intensity;
   assign o_phase                 = r_phase;
   assign o_update_rate_intensity = r_rate_intensity;
   assign o_update_rate_phase     = r_rate_phase;
   assign o_busy                  = r_busy;
   assign o_done                  = r_done;
   assign o_overrun               = r_overrun;

endmodule

// File: tb/tb_silencer_sequencer.sv
// Scoreboard bench for silencer_sequencer with an event-time frame model.
module tb_silencer_sequencer;

   localparam int DEPTH = 249;
   localparam int LAT   = 2;
   localparam int MAXC  = 20000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_trig = 1'b0;
   logic [15:0] cfg_i = 16'h0;
   logic [15:0] cfg_p = 16'h0;
   logic        i_overrun_clr = 1'b0;
   logic        o_ram_en;
   logic [7:0]  o_ram_addr;
   logic [15:0] ram_i = 16'h0;
   logic [7:0]  ram_p = 8'h0;
   logic        o_din_valid;
   logic [15:0] o_intensity;
   logic [7:0]  o_phase;
   logic [15:0] o_rate_i;
   logic [15:0] o_rate_p;
   logic        dout_v;
   logic        o_busy;
   logic        o_done;
   logic        o_overrun;

   silencer_sequencer #(.DEPTH(DEPTH), .RAM_LATENCY(LAT)) dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .i_trig                      (i_trig),
      .i_update_rate_intensity_cfg (cfg_i),
      .i_update_rate_phase_cfg     (cfg_p),
      .i_overrun_clr               (i_overrun_clr),
      .o_ram_en                    (o_ram_en),
      .o_ram_addr                  (o_ram_addr),
      .i_ram_intensity             (ram_i),
      .i_ram_phase                 (ram_p),
      .o_din_valid                 (o_din_valid),
      .o_intensity                 (o_intensity),
      .o_phase                     (o_phase),
      .o_update_rate_intensity     (o_rate_i),
      .o_update_rate_phase         (o_rate_p),
      .i_dout_valid                (dout_v),
      .o_busy                      (o_busy),
      .o_done                      (o_done),
      .o_overrun                   (o_overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // Synchronous RAM and fixed-delay interpolator surrounding the DUT.
   logic [15:0] mem_i [DEPTH];
   logic [7:0]  mem_p [DEPTH];
   logic [15:0] dpipe = 16'h0;
   int dly = 5;

   always @(posedge clk) begin
      if (o_ram_en) begin
         ram_i <= mem_i[o_ram_addr];
         ram_p <= mem_p[o_ram_addr];
      end
   end

   always @(posedge clk) begin
      if (!rst_n) dpipe <= 16'h0;
      else        dpipe <= {dpipe[14:0], o_din_valid};
   end

   assign dout_v = (dly == 0) ? o_din_valid : dpipe[dly-1];

   // Reference model state: frames as (accept cycle, length) pairs.
   typedef struct {
      int cyc;
      int inten;
      int ph;
      int acc;
   } din_t;

   din_t din_q[$];
   int   done_q[$];
   int   fr_acc[$];
   int   fr_len[$];
   int   last_acc = -100000;
   int   last_end = -100000;
   bit   ov_cur = 1'b0;
   bit   exp_ov [MAXC];
   int   hist_i [MAXC];
   int   hist_p [MAXC];
   bit   started = 1'b0;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp_v);
      end
   endtask

   task automatic add_frame(input int a);
      int flen;
      flen = DEPTH + LAT + dly + 1;
      fr_acc.push_back(a);
      fr_len.push_back(flen);
      last_acc = a;
      last_end = a + flen;
      for (int k = 0; k < DEPTH; k++) begin
         din_t d;
         d.cyc   = a + 1 + LAT + k;
         d.inten = int'(mem_i[k]);
         d.ph    = int'(mem_p[k]);
         d.acc   = a;
         din_q.push_back(d);
      end
      done_q.push_back(a + flen);
   endtask

   // Drive one cycle of stimulus and advance the model.
   task automatic drive_cycle(input bit trig, input bit clr);
      bit ov_set;
      ov_set = 1'b0;
      i_trig = trig;
      i_overrun_clr = clr;
      hist_i[cyc] = int'(cfg_i);
      hist_p[cyc] = int'(cfg_p);
      if (trig) begin
         if (cyc >= last_end)      add_frame(cyc);
         else if (cyc >= last_acc) add_frame(last_end);
         else                      ov_set = 1'b1;
      end
      if (ov_set)   ov_cur = 1'b1;
      else if (clr) ov_cur = 1'b0;
      exp_ov[cyc+1] = ov_cur;
   endtask

   task automatic step(input bit trig, input bit clr);
      @(posedge clk);
      #1;
      drive_cycle(trig, clr);
   endtask

   task automatic wait_idle();
      while (cyc <= last_end + 1) step(1'b0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ram_en"},    int'(o_ram_en), 0);
      chk({tag, "_ram_addr"},  int'(o_ram_addr), 0);
      chk({tag, "_din_valid"}, int'(o_din_valid), 0);
      chk({tag, "_intensity"}, int'(o_intensity), 0);
      chk({tag, "_phase"},     int'(o_phase), 0);
      chk({tag, "_rate_i"},    int'(o_rate_i), 0);
      chk({tag, "_rate_p"},    int'(o_rate_p), 0);
      chk({tag, "_busy"},      int'(o_busy), 0);
      chk({tag, "_done"},      int'(o_done), 0);
      chk({tag, "_overrun"},   int'(o_overrun), 0);
   endtask

   // Asynchronous reset in the middle of a cycle, then model flush.
   task automatic mid_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      din_q.delete();
      done_q.delete();
      fr_acc.delete();
      fr_len.delete();
      last_acc = -100000;
      last_end = -100000;
      ov_cur = 1'b0;
      exp_ov[cyc+1] = 1'b0;
      i_trig = 1'b0;
      i_overrun_clr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b0);
   endtask

   // Monitor: per-cycle control checks plus scoreboard pops on DUT strobes.
   always @(negedge clk) begin
      if (rst_n && started) begin
         int c;
         bit e_busy;
         bit e_en;
         int e_addr;
         c = cyc;
         e_busy = 1'b0;
         e_en = 1'b0;
         e_addr = 0;
         for (int f = 0; f < fr_acc.size(); f++) begin
            if (fr_acc[f] < c && c < fr_acc[f] + fr_len[f]) e_busy = 1'b1;
            if (c >= fr_acc[f] + 1 && c <= fr_acc[f] + DEPTH) begin
               e_en = 1'b1;
               e_addr = c - fr_acc[f] - 1;
            end
         end
         chk("busy", int'(o_busy), int'(e_busy));
         chk("ram_en", int'(o_ram_en), int'(e_en));
         if (e_en) chk("ram_addr", int'(o_ram_addr), e_addr);
         chk("overrun", int'(o_overrun), int'(exp_ov[c]));
         if (o_din_valid) begin
            if (din_q.size() == 0) begin
               chk("din_unexpected", 1, 0);
            end else begin
               din_t d;
               d = din_q.pop_front();
               chk("din_cycle", c, d.cyc);
               chk("intensity", int'(o_intensity), d.inten);
               chk("phase", int'(o_phase), d.ph);
               chk("rate_i", int'(o_rate_i), hist_i[d.acc]);
               chk("rate_p", int'(o_rate_p), hist_p[d.acc]);
            end
         end
         if (o_done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else                    chk("done_cycle", c, done_q.pop_front());
         end
      end
   end

   initial begin
      for (int k = 0; k < DEPTH; k++) begin
         mem_i[k] = 16'($urandom);
         mem_p[k] = 8'($urandom);
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      drive_cycle(1'b0, 1'b0);
      started = 1'b1;

      // Phase A: trigger at 10, queued trigger at 50, config change mid-frame.
      cfg_i = 16'h0100;
      cfg_p = 16'h0100;
      while (cyc < 540) begin
         @(posedge clk);
         #1;
         if (cyc == 100) begin
            cfg_i = 16'h0200;
            cfg_p = 16'h0200;
         end
         drive_cycle(cyc == 10 || cyc == 50, 1'b0);
      end

      // Phase B: third trigger while one is queued, then clear overrun.
      begin
         int base;
         wait_idle();
         base = cyc + 5;
         while (cyc < base + 540) begin
            @(posedge clk);
            #1;
            drive_cycle(cyc == base || cyc == base + 40 || cyc == base + 50,
                        cyc == base + 290);
         end
      end

      // Phase C: random triggers, clears and configs with varied interpolator delay.
      for (int s = 0; s < 2; s++) begin
         wait_idle();
         dly = (s == 0) ? 0 : int'($urandom_range(1, 8));
         repeat (1500) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 29) == 0) begin
               cfg_i = 16'($urandom);
               cfg_p = 16'($urandom);
            end
            drive_cycle($urandom_range(0, 69) == 0, $urandom_range(0, 49) == 0);
         end
      end

      // Phase D: overrun set, reset mid-fetch, silence, then a clean frame.
      begin
         int base;
         wait_idle();
         dly = 5;
         base = cyc + 3;
         while (cyc < base + 90) begin
            @(posedge clk);
            #1;
            drive_cycle(cyc == base || cyc == base + 10 || cyc == base + 20, 1'b0);
         end
         mid_reset();
         repeat (300) step(1'b0, 1'b0);
         step(1'b1, 1'b0);
         wait_idle();
         repeat (5) step(1'b0, 1'b0);
      end

      chk("din_left", din_q.size(), 0);
      chk("done_left", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
